song_recorder: RTL and testbench

Captures monophonic live key presses into a song RAM using the same 16-bit word format that `song_reader` plays back, so a recorded song replays unchanged. It sits between the keypad/note-input logic and a writable song memory, and takes `beat` from the existing beat generator. Each note is written when its key is released. Each gap between presses is written as one or more advance-time words.

---
 rtl/song_pkg.sv | 46 ++++
 rtl/song_recorder_if.sv | 30 +++
 rtl/sat_beat_counter.sv | 25 ++
 rtl/song_recorder.sv | 227 ++++++++++++++++++++++
 tb/tb_song_recorder.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// Shared widths, song-word field layout and recorder state encoding for the song
// reader/recorder pair; word constructors keep both sides on one format.
package song_pkg;

  localparam int SONG_WIDTH     = 5;  // word-index bits inside one song slot
  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int SLOT_WIDTH     = 2;
  localparam int ADDR_WIDTH     = SLOT_WIDTH + SONG_WIDTH;
  localparam int WORD_WIDTH     = 16;
  localparam int COUNT_WIDTH    = SONG_WIDTH + 1;

  localparam int ADV_FLAG_BIT  = 15;
  localparam int NOTE_LSB      = 9;
  localparam int DURATION_LSB  = 3;
  localparam int ADV_BEATS_LSB = 9;
  localparam int MAX_FIELD     = 63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_WR_ADV,
    ST_WR_NOTE,
    ST_FLUSH,
    ST_CLEAR,
    ST_DONE
  } rec_state_t;

  function automatic logic [WORD_WIDTH-1:0] note_word(input logic [NOTE_WIDTH-1:0] note,
                                                      input logic [DURATION_WIDTH-1:0] dur);
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    w[NOTE_LSB +: NOTE_WIDTH] = note;
    w[DURATION_LSB +: DURATION_WIDTH] = dur;
    return w;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] adv_word(input logic [DURATION_WIDTH-1:0] beats);
    logic [WORD_WIDTH-1:0] w;
    w = '0;
    w[ADV_FLAG_BIT] = 1'b1;
    w[ADV_BEATS_LSB +: DURATION_WIDTH] = beats;
    return w;
  endfunction

endpackage

// File: rtl/song_recorder_if.sv
// Keypad-side inputs, song-RAM write port and status of song_recorder.
interface song_recorder_if;
  import song_pkg::*;

  logic                   record;
  logic [SLOT_WIDTH-1:0]  song;
  logic                   beat;
  logic                   key_down;
  logic [NOTE_WIDTH-1:0]  key_note;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [WORD_WIDTH-1:0]  wr_data;
  logic                   busy;
  logic                   record_full;
  logic                   record_done;
  logic [COUNT_WIDTH-1:0] words_written;
  rec_state_t             state;

  // The RAM port has no ready: every cycle with wr_en high is one committed write of
  // wr_data to wr_addr, and the recorder never issues more than one per cycle.
  modport slave (
    input  record, song, beat, key_down, key_note,
    output wr_en, wr_addr, wr_data, busy, record_full, record_done, words_written, state
  );

  modport master (
    output record, song, beat, key_down, key_note,
    input  wr_en, wr_addr, wr_data, busy, record_full, record_done, words_written, state
  );
endinterface

// File: rtl/sat_beat_counter.sv
// Beat counter that saturates at MAX_VAL; clear wins over increment.
module sat_beat_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count_next  // current count with this cycle's beat applied
);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count;

  always_comb begin
    count_next = count;
    if (inc && count != MAX_C) count_next = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else                count <= count_next;
  end
endmodule

// File: rtl/song_recorder.sv
// Records live key presses as note/advance words into song RAM.
// Optional SONG_RECORDER_CLEAR_TAIL_EN zero-fills the unused tail of the slot at stop.
module song_recorder
  import song_pkg::*;
#(
  parameter int MAX_GAP = 255
) (
  input logic            clk,
  input logic            reset,
  song_recorder_if.slave bus
);
  localparam logic [SONG_WIDTH-1:0] LAST_IDX = SONG_WIDTH'((1 << SONG_WIDTH) - 1);

  rec_state_t                state_q, state_d;
  logic [SLOT_WIDTH-1:0]     slot_q, slot_d;
  logic [SONG_WIDTH-1:0]     idx_q, idx_d;
  logic [7:0]                adv_rem_q, adv_rem_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic                      note_active_q, note_active_d;
  logic                      stopping_q, stopping_d;
  logic                      full_q, full_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [COUNT_WIDTH-1:0]    words_written_q, words_written_d;

  logic [7:0]                gap_now;
  logic [DURATION_WIDTH-1:0] held_now;
  logic                      gap_clr, held_clr;
  logic                      real_wr, last_wr;
  logic [SONG_WIDTH-1:0]     wr_idx;
  logic                      start_adv, start_note, finish;
  logic [7:0]                adv_src;
  logic [DURATION_WIDTH-1:0] chunk;

  // Gap counts silence between a release and the next press; held counts the note.
  sat_beat_counter #(.WIDTH(8), .MAX_VAL(MAX_GAP)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (gap_clr),
    .inc        (bus.beat && !note_active_q && state_q != ST_IDLE),
    .count_next (gap_now)
  );

  sat_beat_counter #(.WIDTH(DURATION_WIDTH), .MAX_VAL(MAX_FIELD)) u_held_cnt (
    .clk        (clk),
    .reset      (reset),
    .clear      (held_clr),
    .inc        (bus.beat && note_active_q && state_q != ST_IDLE),
    .count_next (held_now)
  );

  assign real_wr = wr_en_q && (state_q != ST_CLEAR);
  assign last_wr = wr_en_q && (idx_q == LAST_IDX);
  assign wr_idx  = idx_q + {{(SONG_WIDTH-1){1'b0}}, wr_en_q};

  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    idx_d           = wr_idx;
    adv_rem_d       = adv_rem_q;
    note_d          = note_q;
    note_active_d   = note_active_q;
    stopping_d      = stopping_q;
    full_d          = full_q;
    words_written_d = words_written_q + {{(COUNT_WIDTH-1){1'b0}}, real_wr};
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    gap_clr         = 1'b0;
    held_clr        = 1'b0;
    start_adv       = 1'b0;
    start_note      = 1'b0;
    finish          = 1'b0;
    adv_src         = '0;
    chunk           = '0;

    // A write landing on the last slot word ends the session whatever else is pending.
    if (last_wr) begin
      state_d = ST_DONE;
      full_d  = full_q | real_wr;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gap_clr       = 1'b1;
          held_clr      = 1'b1;
          adv_rem_d     = '0;
          note_active_d = 1'b0;
          stopping_d    = 1'b0;
          if (bus.record) begin
            state_d         = ST_RECORD;
            slot_d          = bus.song;
            idx_d           = '0;
            words_written_d = '0;
            full_d          = 1'b0;
          end
        end
        ST_RECORD: begin
          if (!bus.record) begin
            stopping_d = 1'b1;
            state_d    = ST_FLUSH;
          end else if (bus.key_down && !note_active_q) begin
            note_d        = bus.key_note;
            note_active_d = 1'b1;
            held_clr      = 1'b1;
            gap_clr       = 1'b1;
            if (gap_now != 8'd0) begin
              start_adv = 1'b1;
              adv_src   = gap_now;
            end
          end else if (!bus.key_down && note_active_q) begin
            start_note = 1'b1;
          end
        end
        ST_WR_ADV: begin
          if (adv_rem_q != 8'd0) begin
            start_adv = 1'b1;
            adv_src   = adv_rem_q;
          end else if (stopping_q) begin
            finish = 1'b1;
          end else begin
            state_d = ST_RECORD;
          end
        end
        ST_WR_NOTE: state_d = stopping_q ? ST_FLUSH : ST_RECORD;
        ST_FLUSH: begin
          if (note_active_q) begin
            start_note = 1'b1;
          end else if (gap_now != 8'd0) begin
            gap_clr   = 1'b1;
            start_adv = 1'b1;
            adv_src   = gap_now;
          end else begin
            finish = 1'b1;
          end
        end
        ST_CLEAR: begin
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
          wr_en_d   = 1'b1;
          wr_addr_d = {slot_q, wr_idx};
          wr_data_d = '0;
`else
          state_d = ST_DONE;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (start_adv) begin
      chunk     = (adv_src > 8'd63) ? DURATION_WIDTH'(MAX_FIELD) : adv_src[DURATION_WIDTH-1:0];
      adv_rem_d = adv_src - {2'b00, chunk};
      state_d   = ST_WR_ADV;
      wr_en_d   = 1'b1;
      wr_addr_d = {slot_q, wr_idx};
      wr_data_d = adv_word(chunk);
    end

    if (start_note) begin
      note_active_d = 1'b0;
      state_d       = ST_WR_NOTE;
      wr_en_d       = 1'b1;
      wr_addr_d     = {slot_q, wr_idx};
      wr_data_d     = note_word(note_q, (held_now == '0) ? DURATION_WIDTH'(1) : held_now);
    end

    if (finish) begin
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
      state_d   = ST_CLEAR;
      wr_en_d   = 1'b1;
      wr_addr_d = {slot_q, wr_idx};
      wr_data_d = '0;
`else
      state_d = ST_DONE;
`endif
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      slot_q          <= '0;
      idx_q           <= '0;
      adv_rem_q       <= '0;
      note_q          <= '0;
      note_active_q   <= 1'b0;
      stopping_q      <= 1'b0;
      full_q          <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      idx_q           <= idx_d;
      adv_rem_q       <= adv_rem_d;
      note_q          <= note_d;
      note_active_q   <= note_active_d;
      stopping_q      <= stopping_d;
      full_q          <= full_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      words_written_q <= words_written_d;
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.busy          = busy_q;
  assign bus.record_full   = full_q;
  assign bus.record_done   = done_q;
  assign bus.words_written = words_written_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder: write stream scoreboard plus status checks.
module tb_song_recorder;
  import song_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   done_seen;
  logic [22:0] exp_q[$];
  logic [22:0] exp_w;

  song_recorder_if bus();

  song_recorder #(.MAX_GAP(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.beat = 1'b1;
      @(negedge clk);
      bus.beat = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push_fill(input logic [1:0] slot, input int from);
    for (int i = from; i < 32; i++) push_wr({slot, 5'(i)}, 16'h0000);
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.record_done) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  task automatic start_session(input logic [1:0] slot);
    bus.song   = slot;
    bus.record = 1'b1;
    tick(1);
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("write_when_none_expected", 32'(bus.wr_en), 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {9'b0, bus.wr_addr, bus.wr_data}, {9'b0, exp_w});
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.record   = 1'b0;
    bus.song     = 2'd0;
    bus.beat     = 1'b0;
    bus.key_down = 1'b0;
    bus.key_note = 6'd0;
    tick(3);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_full", 32'(bus.record_full), 32'd0);
    check("rst_done", 32'(bus.record_done), 32'd0);
    check("rst_words", 32'(bus.words_written), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    reset = 1'b0;
    tick(1);

    // song 2: note 12 pressed at once, held 4 beats -> note word at addr 64
    push_wr(7'd64, 16'h1820);
    bus.key_note = 6'd12;
    bus.key_down = 1'b1;
    start_session(2'd2);
    check("s1_busy", 32'(bus.busy), 32'd1);
    tick(1);
    beats(4);
    tick(4);
    bus.key_down = 1'b0;
    tick(2);
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
    push_fill(2'd2, 1);
`endif
    bus.record = 1'b0;
    wait_done("s1_done");
    check("s1_busy_in_done", 32'(bus.busy), 32'd1);
    check("s1_words", 32'(bus.words_written), 32'd1);
    check("s1_full", 32'(bus.record_full), 32'd0);
    tick(1);
    check("s1_idle_busy", 32'(bus.busy), 32'd0);
    check("s1_done_pulse", 32'(bus.record_done), 32'd0);

    // song 1: gap of 3 beats, note 5 held 2 beats, stop while held
    start_session(2'd1);
    beats(3);
    push_wr(7'd32, 16'h8600);
    bus.key_note = 6'd5;
    bus.key_down = 1'b1;
    tick(1);
    check("s2_state_adv", 32'(bus.state), 32'(ST_WR_ADV));
    tick(2);
    beats(2);
    tick(2);
    push_wr(7'd33, 16'h0A10);
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
    push_fill(2'd1, 2);
`endif
    bus.record = 1'b0;
    wait_done("s2_done");
    check("s2_words", 32'(bus.words_written), 32'd2);
    bus.key_down = 1'b0;
    tick(2);

    // song 3: 130-beat gap splits into 63, 63, 4 on back-to-back cycles
    start_session(2'd3);
    beats(130);
    push_wr(7'd96, 16'hFE00);
    push_wr(7'd97, 16'hFE00);
    push_wr(7'd98, 16'h8800);
    bus.key_note = 6'd7;
    bus.key_down = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("s3_adv_burst", 32'(bus.wr_en), 32'd1);
    end
    tick(1);
    check("s3_burst_end", 32'(bus.wr_en), 32'd0);
    tick(4);
    beats(1);
    push_wr(7'd99, 16'h0E08);
    bus.key_down = 1'b0;
    tick(2);
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
    push_fill(2'd3, 4);
`endif
    bus.record = 1'b0;
    wait_done("s3_done");
    check("s3_words", 32'(bus.words_written), 32'd4);
    tick(2);

    // song 0: press on a beat credits the gap, zero-beat hold clamps to 1
    start_session(2'd0);
    beats(2);
    push_wr(7'd0, 16'h8600);
    push_wr(7'd1, 16'h1208);
    bus.key_note = 6'd9;
    bus.key_down = 1'b1;
    bus.beat     = 1'b1;
    tick(1);
    bus.beat = 1'b0;
    check("s4_state_adv", 32'(bus.state), 32'(ST_WR_ADV));
    tick(9);
    bus.key_down = 1'b0;
    tick(2);
`ifdef SONG_RECORDER_CLEAR_TAIL_EN
    push_fill(2'd0, 2);
`endif
    bus.record = 1'b0;
    wait_done("s4_done");
    check("s4_words", 32'(bus.words_written), 32'd2);
    tick(2);

    // song 1: 40 press/release pairs, writes must stop after index 31
    start_session(2'd1);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      bus.key_note = 6'(i);
      if (i < 32) push_wr({2'd1, 5'(i)}, {1'b0, 6'(i), 6'd1, 3'b000});
      bus.key_down = 1'b1;
      tick(8);
      bus.key_down = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick(1);
        if (bus.record_done) begin
          done_seen++;
          bus.record = 1'b0;
        end
      end
    end
    check("s5_done_once", 32'(done_seen), 32'd1);
    check("s5_full", 32'(bus.record_full), 32'd1);
    check("s5_words", 32'(bus.words_written), 32'd32);
    check("s5_busy", 32'(bus.busy), 32'd0);

    // song 2: reset while an advance word is being written
    start_session(2'd2);
    check("s6_full_cleared", 32'(bus.record_full), 32'd0);
    check("s6_words_cleared", 32'(bus.words_written), 32'd0);
    beats(5);
    push_wr(7'd64, 16'h8A00);
    bus.key_note = 6'd3;
    bus.key_down = 1'b1;
    tick(1);
    check("s6_state_adv", 32'(bus.state), 32'(ST_WR_ADV));
    reset = 1'b1;
    tick(1);
    check("s6_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("s6_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("s6_rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("s6_rst_busy", 32'(bus.busy), 32'd0);
    check("s6_rst_words", 32'(bus.words_written), 32'd0);
    check("s6_rst_state", 32'(bus.state), 32'(ST_IDLE));
    reset        = 1'b0;
    bus.record   = 1'b0;
    bus.key_down = 1'b0;
    tick(3);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
